reaction_round_sequencer: RTL

Round controller for the reaction-timer datapath. Sequences a multi-trial round:
- arms on a start press;
- waits a pseudo-random foreperiod;
- lights the stimulus;
- measures reaction time in 1 ms ticks;
- shows each result, then shows best and average at round end.

It sits between the debounced buttons and 1 kHz strobe on one side, and the LED and seven-segment drivers on the other. It replaces ad-hoc sequencing with one explicit state machine.

---
 rtl/reaction_pkg.sv | 13 +
 rtl/reaction_round_sequencer_lfsr16.sv | 16 +
 rtl/reaction_round_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: state encodings, LFSR constants and default timing for the reaction-timer round controller.
package reaction_pkg;
   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_STIM, S_FALSE, S_SHOW, S_SUMMARY} state_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shift Galois taps for x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int DEF_NUM_TRIALS   = 4;
   localparam int DEF_MIN_DELAY_MS = 1000;
   localparam int DEF_DELAY_MASK   = 1023;
   localparam int DEF_TIMEOUT_MS   = 9999;
   localparam int DEF_SHOW_MS      = 2000;
   localparam int DEF_TIME_W       = 14;
endpackage

// File: rtl/reaction_round_sequencer_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lockup state.
module lfsr16
   import reaction_pkg::*;
(
   input  logic        clk,
   input  logic        ck_rst,
   output logic [15:0] lfsr_o
);
   logic [15:0] lfsr_q, lfsr_d;
   assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
   assign lfsr_o = lfsr_q;
   always_ff @(posedge clk) begin
      if (ck_rst) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end
endmodule

// File: rtl/reaction_round_sequencer.sv
// reaction_round_sequencer: multi-trial reaction-timer round FSM with random foreperiod,
// false-start detection, per-trial display and best/average summary.
module reaction_round_sequencer
   import reaction_pkg::*;
#(
   parameter int NUM_TRIALS   = DEF_NUM_TRIALS,
   parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
   parameter int DELAY_MASK   = DEF_DELAY_MASK,
   parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS,
   parameter int SHOW_MS      = DEF_SHOW_MS,
   parameter int TIME_W       = DEF_TIME_W
) (
   input  logic              clk,
   input  logic              ck_rst,
   input  logic              tick_1ms,
   input  logic              start_btn,
   input  logic              react_btn,
   output logic              armed,
   output logic              stimulus_on,
   output logic              false_start,
   output logic              result_valid,
   output logic [TIME_W-1:0] result_ms,
   output logic [2:0]        trial_idx,
   output logic [TIME_W-1:0] best_ms,
   output logic [TIME_W-1:0] avg_ms,
   output logic              round_done
);
   localparam int                SUM_W     = TIME_W + 3;
   localparam int                SH        = $clog2(NUM_TRIALS);
   localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);
   localparam logic [TIME_W-1:0] MIN_T     = TIME_W'(MIN_DELAY_MS);
   localparam logic [TIME_W-1:0] TIMEOUT_T = TIME_W'(TIMEOUT_MS);
   localparam logic [TIME_W-1:0] SHOW_T    = TIME_W'(SHOW_MS);
   localparam logic [9:0]        MASK_T    = 10'(DELAY_MASK);
   localparam logic [2:0]        LAST_T    = 3'(NUM_TRIALS - 1);
   state_t state_q, state_d;
   logic start_q, react_q, start_e, react_e, record;
   logic armed_q, stim_q, fs_q, valid_q, done_q;
   logic [15:0] lfsr_w;
   logic [5:0] lfsr_unused;
   logic [TIME_W-1:0] delay_q, delay_d, hold_q, hold_d, ms_q, ms_d;
   logic [TIME_W-1:0] best_q, best_d, result_q, result_d, avg_q, new_delay, rec;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [2:0] trial_q, trial_d;
   lfsr16 u_lfsr (.clk(clk), .ck_rst(ck_rst), .lfsr_o(lfsr_w));
   assign lfsr_unused = lfsr_w[15:10];
   assign new_delay   = MIN_T + {{(TIME_W-10){1'b0}}, lfsr_w[9:0] & MASK_T};
   assign start_e     = start_btn & ~start_q;
   assign react_e     = react_btn & ~react_q;
   always_comb begin
      state_d  = state_q;
      delay_d  = delay_q;
      hold_d   = hold_q;
      ms_d     = ms_q;
      sum_d    = sum_q;
      best_d   = best_q;
      result_d = result_q;
      trial_d  = trial_q;
      rec      = ms_q;
      record   = 1'b0;
      case (state_q)
         S_IDLE, S_SUMMARY: if (start_e) begin
            state_d = S_DELAY;
            trial_d = '0;
            sum_d   = '0;
            best_d  = '1;
            delay_d = new_delay;
         end
         // A press on the final foreperiod tick still counts as early.
         S_DELAY: if (react_e) begin
            state_d = S_FALSE;
            hold_d  = SHOW_T;
         end else if (tick_1ms) begin
            delay_d = delay_q - ONE;
            if (delay_q == ONE) begin
               state_d = S_STIM;
               ms_d    = '0;
            end
         end
         S_FALSE: if (tick_1ms) begin
            hold_d = hold_q - ONE;
            if (hold_q == ONE) begin
               state_d = S_DELAY;
               delay_d = new_delay;
            end
         end
         // React beats a coincident tick, so the pre-increment count is recorded.
         S_STIM: if (react_e) record = 1'b1;
         else if (tick_1ms) begin
            ms_d = ms_q + ONE;
            if (ms_d == TIMEOUT_T) begin
               record = 1'b1;
               rec    = TIMEOUT_T;
            end
         end
         S_SHOW: if (tick_1ms) begin
            hold_d = hold_q - ONE;
            if (hold_q == ONE && trial_q == LAST_T) begin
               state_d  = S_SUMMARY;
               result_d = TIME_W'(sum_q >> SH);
            end else if (hold_q == ONE) begin
               state_d = S_DELAY;
               trial_d = trial_q + 3'd1;
               delay_d = new_delay;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (record) begin
         state_d  = S_SHOW;
         hold_d   = SHOW_T;
         result_d = rec;
         sum_d    = sum_q + SUM_W'(rec);
         best_d   = (rec < best_q) ? rec : best_q;
      end
   end
   always_ff @(posedge clk) begin
      if (ck_rst) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b1;
         react_q  <= 1'b1;
         delay_q  <= '0;
         hold_q   <= '0;
         ms_q     <= '0;
         sum_q    <= '0;
         best_q   <= '1;
         result_q <= '0;
         trial_q  <= '0;
         avg_q    <= '0;
         armed_q  <= 1'b1;
         stim_q   <= 1'b0;
         fs_q     <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_btn;
         react_q  <= react_btn;
         delay_q  <= delay_d;
         hold_q   <= hold_d;
         ms_q     <= ms_d;
         sum_q    <= sum_d;
         best_q   <= best_d;
         result_q <= result_d;
         trial_q  <= trial_d;
         avg_q    <= TIME_W'(sum_d >> SH);
         armed_q  <= state_d == S_IDLE;
         stim_q   <= state_d == S_STIM;
         fs_q     <= state_d == S_FALSE;
         valid_q  <= state_d == S_SHOW || state_d == S_SUMMARY;
         done_q   <= state_d == S_SUMMARY;
      end
   end
   assign armed        = armed_q;
   assign stimulus_on  = stim_q;
   assign false_start  = fs_q;
   assign result_valid = valid_q;
   assign result_ms    = result_q;
   assign trial_idx    = trial_q;
   assign best_ms      = best_q;
   assign avg_ms       = avg_q;
   assign round_done   = done_q;
endmodule
